// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the round-robin stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int ARB_CNT_WIDTH = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The request vector is duplicated so the wrap becomes a plain lowest-bit search.
module rr_priority_picker #(
    parameter int NUM_IN = 4,
    localparam int IDX_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  index
);

    logic [2*NUM_IN-1:0] req_dbl;
    logic [2*NUM_IN-1:0] masked;

    always_comb begin
        req_dbl = {req, req};
        masked  = '0;
        for (int i = 0; i < 2*NUM_IN; i++) begin
            masked[i] = req_dbl[i] && (i >= int'(ptr));
        end
    end

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 2*NUM_IN-1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                index = IDX_W'(i % NUM_IN);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI4-Stream output among NUM_IN
// requesters, granting each for at most BURST_LEN beats.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 4,
    parameter int BURST_LEN  = 4,
    localparam int IDX_W     = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         busy
);

    localparam logic [ARB_CNT_WIDTH-1:0] LAST_BEAT = ARB_CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_IN - 1);

    arb_state_t              state;
    logic [IDX_W-1:0]        ptr;
    logic [ARB_CNT_WIDTH-1:0] count;
    logic                    found;
    logic [IDX_W-1:0]        pick;
    logic                    sel_valid;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    xfer;

    rr_priority_picker #(
        .NUM_IN (NUM_IN)
    ) u_picker (
        .req   (in_valid),
        .ptr   (ptr),
        .found (found),
        .index (pick)
    );

    assign sel_valid = in_valid[grant_id];
    assign sel_data  = in_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

    // Ready only looks at the output register, so out_ready reaches in_ready
    // through one gate and never reaches out_valid/out_data combinationally.
    always_comb begin
        in_ready = '0;
        if (state == ARB_GRANT) begin
            in_ready[grant_id] = ~out_valid | out_ready;
        end
    end

    assign xfer = sel_valid & in_ready[grant_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            count     <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (xfer) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        state    <= ARB_GRANT;
                        grant_id <= pick;
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (xfer) begin
                        count <= count + 1'b1;
                    end
                    if ((xfer && count == LAST_BEAT) || !sel_valid) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                        ptr   <= (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
